// File: rtl/md5_sched_pkg.sv
// Shared state encoding and default widths for the MD5 job scheduler.
package md5_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } sched_state_t;

    localparam int KEY_W_DEF   = 32;
    localparam int CHUNK_W_DEF = 16;

endpackage

// File: rtl/md5_rr_pick.sv
// Combinational round-robin picker: grants the lowest-index free engine
// at or after ptr, wrapping around the engine array.
module md5_rr_pick #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  free,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [PW-1:0]  off;
    logic [PW:0]    sum;

    always_comb begin
        // Rotate so bit 0 of rot is the engine at ptr.
        dbl   = {free, free} >> ptr;
        rot   = dbl[N-1:0];
        valid = |rot;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = PW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (PW + 1)'(N)) sum = sum - (PW + 1)'(N);
        grant = valid ? (N'(1) << sum) : '0;
    end

endmodule

// File: rtl/md5_job_scheduler.sv
// Splits a key range into chunks, dispatches them round-robin to the MD5
// engines and reports the first match. Optional cycle counter: MD5_SCHED_PERF_EN.
module md5_job_scheduler
    import md5_sched_pkg::*;
#(
    parameter int NUM_ENG = 4,
    parameter int KEY_W   = KEY_W_DEF,
    parameter int CHUNK_W = CHUNK_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [KEY_W-1:0]           range_base,
    input  logic [KEY_W-1:0]           range_end,
    input  logic [CHUNK_W-1:0]         chunk_size,
    output logic [NUM_ENG-1:0]         eng_start,
    output logic [NUM_ENG*KEY_W-1:0]   eng_base,
    output logic [NUM_ENG*CHUNK_W-1:0] eng_count,
    output logic [NUM_ENG-1:0]         eng_abort,
    input  logic [NUM_ENG-1:0]         eng_busy,
    input  logic [NUM_ENG-1:0]         eng_done,
    input  logic [NUM_ENG-1:0]         eng_found,
    input  logic [NUM_ENG*KEY_W-1:0]   eng_key,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic [KEY_W-1:0]           found_key,
    output logic [31:0]                chunks_issued,
    output logic [31:0]                perf_cycles
);

    localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    sched_state_t state, state_nxt;

    logic [KEY_W:0]       next_q;
    logic [KEY_W-1:0]     end_q;
    logic [CHUNK_W-1:0]   chunk_q;
    logic [NUM_ENG-1:0]   pend_q, pend_nxt, start_q, abort_q;
    logic [KEY_W-1:0]     base_q [NUM_ENG];
    logic [CHUNK_W-1:0]   cnt_q  [NUM_ENG];
    logic [KEY_W-1:0]     key_a  [NUM_ENG];
    logic                 done_q, found_q;
    logic [KEY_W-1:0]     key_q;
    logic [31:0]          issued_q;
    logic [PTR_W-1:0]     ptr_q, ptr_nxt, gidx;

    logic [NUM_ENG-1:0]   free, grant, hit;
    logic                 grant_valid, issue, new_match, all_idle, busy_st;
    logic [KEY_W:0]       remain, chunk_ext, cnt_w, next_adv;
    logic [KEY_W-1:0]     mkey;

    for (genvar g = 0; g < NUM_ENG; g++) begin : g_eng
        assign key_a[g]                        = eng_key[g*KEY_W +: KEY_W];
        assign eng_base[g*KEY_W +: KEY_W]      = base_q[g];
        assign eng_count[g*CHUNK_W +: CHUNK_W] = cnt_q[g];
    end

    assign free = ~eng_busy & ~pend_q;

    md5_rr_pick #(.N(NUM_ENG)) u_pick (
        .free  (free),
        .ptr   (ptr_q),
        .grant (grant),
        .valid (grant_valid)
    );

    assign busy_st = (state == DISPATCH) || (state == DRAIN);
    assign issue   = (state == DISPATCH) && grant_valid && !abort;
    assign hit       = eng_done & eng_found;
    assign new_match = busy_st && (|hit) && !found_q;

    // Range arithmetic is one bit wider so an all-ones range_end cannot wrap.
    assign remain    = {1'b0, end_q} - next_q + (KEY_W + 1)'(1);
    assign chunk_ext = {{(KEY_W + 1 - CHUNK_W){1'b0}}, chunk_q};
    assign cnt_w     = (chunk_ext < remain) ? chunk_ext : remain;
    assign next_adv  = next_q + cnt_w;

    assign pend_nxt = (pend_q & ~(eng_busy | eng_done)) | (issue ? grant : '0);
    assign all_idle = ~|eng_busy && ~|pend_nxt;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (grant[i]) gidx = PTR_W'(i);
        end
        ptr_nxt = (gidx == PTR_W'(NUM_ENG - 1)) ? '0 : gidx + PTR_W'(1);
    end

    always_comb begin
        mkey = '0;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (hit[i]) mkey = key_a[i];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (range_end < range_base) ? DONE : DISPATCH;
            end
            DISPATCH: begin
                if (new_match || abort)                           state_nxt = DRAIN;
                else if (issue && (next_adv > {1'b0, end_q}))     state_nxt = DRAIN;
            end
            DRAIN: begin
                if (all_idle) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            next_q   <= '0;
            end_q    <= '0;
            chunk_q  <= '0;
            pend_q   <= '0;
            start_q  <= '0;
            abort_q  <= '0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            key_q    <= '0;
            issued_q <= '0;
            ptr_q    <= '0;
            for (int i = 0; i < NUM_ENG; i++) begin
                base_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state   <= state_nxt;
            pend_q  <= pend_nxt;
            start_q <= issue ? grant : '0;

            if (state == IDLE && start) begin
                next_q   <= {1'b0, range_base};
                end_q    <= range_end;
                chunk_q  <= (chunk_size == '0) ? CHUNK_W'(1) : chunk_size;
                done_q   <= 1'b0;
                found_q  <= 1'b0;
                issued_q <= '0;
                ptr_q    <= '0;
                abort_q  <= '0;
            end

            if (issue) begin
                next_q   <= next_adv;
                issued_q <= issued_q + 32'd1;
                ptr_q    <= ptr_nxt;
                for (int i = 0; i < NUM_ENG; i++) begin
                    if (grant[i]) begin
                        base_q[i] <= next_q[KEY_W-1:0];
                        cnt_q[i]  <= cnt_w[CHUNK_W-1:0];
                    end
                end
            end

            if (busy_st && abort) abort_q <= '1;

            // First match wins; it also stops every engine.
            if (new_match) begin
                found_q <= 1'b1;
                key_q   <= mkey;
                abort_q <= '1;
            end

            if (state == DONE) begin
                done_q  <= 1'b1;
                abort_q <= '0;
            end
        end
    end

    assign eng_start     = start_q;
    assign eng_abort     = abort_q;
    assign busy          = busy_st;
    assign done          = done_q;
    assign found         = found_q;
    assign found_key     = key_q;
    assign chunks_issued = issued_q;

`ifdef MD5_SCHED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset)                         perf_q <= '0;
        else if (state == IDLE && start)   perf_q <= '0;
        else if (busy_st && perf_q != '1)  perf_q <= perf_q + 32'd1;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_md5_job_scheduler.sv
// Scoreboard bench for md5_job_scheduler with a behavioural engine array.
module tb_md5_job_scheduler;

    localparam int NE    = 4;
    localparam int KW    = 32;
    localparam int CW    = 16;
    localparam int LIMIT = 3000;

    logic              clk = 1'b0;
    logic              reset, start, abort;
    logic [KW-1:0]     range_base, range_end;
    logic [CW-1:0]     chunk_size;
    logic [NE-1:0]     eng_start, eng_abort;
    logic [NE*KW-1:0]  eng_base;
    logic [NE*CW-1:0]  eng_count;
    logic [NE-1:0]     eng_busy = '0, eng_done = '0, eng_found = '0;
    logic [NE*KW-1:0]  eng_key;
    logic              busy, done, found;
    logic [KW-1:0]     found_key;
    logic [31:0]       chunks_issued, perf_cycles;

    always #5 clk = ~clk;

    md5_job_scheduler #(.NUM_ENG(NE), .KEY_W(KW), .CHUNK_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .range_base    (range_base),
        .range_end     (range_end),
        .chunk_size    (chunk_size),
        .eng_start     (eng_start),
        .eng_base      (eng_base),
        .eng_count     (eng_count),
        .eng_abort     (eng_abort),
        .eng_busy      (eng_busy),
        .eng_done      (eng_done),
        .eng_found     (eng_found),
        .eng_key       (eng_key),
        .busy          (busy),
        .done          (done),
        .found         (found),
        .found_key     (found_key),
        .chunks_issued (chunks_issued),
        .perf_cycles   (perf_cycles)
    );

    typedef struct {
        logic [KW-1:0] base;
        logic [CW-1:0] cnt;
    } chunk_t;

    typedef struct {
        logic [KW-1:0] base;
        logic [CW-1:0] cnt;
        int            cyc;
        bit            onehot;
    } obs_t;

    chunk_t exp_q[$];
    obs_t   obs_q[$];

    int            n_tests = 0, n_fail = 0;
    int            cyc = 0;
    int            lat [NE];
    logic          fnd [NE];
    logic [KW-1:0] ekey[NE];
    int            ecnt[NE];
    int            t_to, busy_cyc, ab_cyc;
    bit            saw_abort;

    assign eng_key = {ekey[3], ekey[2], ekey[1], ekey[0]};

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: runs lat cycles per chunk, stops at once on eng_abort.
    always @(negedge clk) begin
        for (int i = 0; i < NE; i++) begin
            eng_done[i]  <= 1'b0;
            eng_found[i] <= 1'b0;
            if (reset) begin
                eng_busy[i] <= 1'b0;
                ecnt[i]     <= 0;
            end else if (eng_start[i]) begin
                eng_busy[i] <= 1'b1;
                ecnt[i]     <= lat[i];
            end else if (eng_busy[i]) begin
                if (eng_abort[i]) begin
                    eng_busy[i] <= 1'b0;
                end else if (ecnt[i] <= 1) begin
                    eng_busy[i]  <= 1'b0;
                    eng_done[i]  <= 1'b1;
                    eng_found[i] <= fnd[i];
                end else begin
                    ecnt[i] <= ecnt[i] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && eng_start != '0) begin
            obs_t o;
            int   idx;
            idx = 0;
            for (int i = NE - 1; i >= 0; i--) if (eng_start[i]) idx = i;
            o.base   = eng_base[idx*KW +: KW];
            o.cnt    = eng_count[idx*CW +: CW];
            o.cyc    = cyc;
            o.onehot = $onehot(eng_start);
            obs_q.push_back(o);
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_eng(input int l);
        for (int i = 0; i < NE; i++) begin
            lat[i]  = l;
            fnd[i]  = 1'b0;
            ekey[i] = '0;
        end
    endtask

    task automatic push_chunks(input logic [KW-1:0] b, input logic [KW-1:0] e, input logic [CW-1:0] c);
        logic [KW:0] nx, ce, rem, n;
        chunk_t      ch;
        nx = {1'b0, b};
        ce = (c == 0) ? 33'd1 : {17'd0, c};
        while (nx <= {1'b0, e}) begin
            rem = {1'b0, e} - nx + 33'd1;
            n   = (ce < rem) ? ce : rem;
            ch.base = nx[KW-1:0];
            ch.cnt  = n[CW-1:0];
            exp_q.push_back(ch);
            nx = nx + n;
        end
    endtask

    task automatic run_job(input logic [KW-1:0] b, input logic [KW-1:0] e, input logic [CW-1:0] c,
                           input int abort_at, input int restart_at);
        @(negedge clk);
        range_base = b;
        range_end  = e;
        chunk_size = c;
        start      = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        t_to      = 0;
        busy_cyc  = 0;
        ab_cyc    = -1;
        saw_abort = 1'b0;
        while (!done && t_to < LIMIT) begin
            if (busy) busy_cyc++;
            if (eng_abort == '1) saw_abort = 1'b1;
            abort = (t_to == abort_at);
            if (t_to == abort_at) ab_cyc = cyc;
            start = (t_to == restart_at);
            if (t_to == restart_at) begin
                range_base = 32'd500;
                range_end  = 32'd600;
                chunk_size = 16'd3;
            end
            @(negedge clk);
            t_to++;
        end
        abort = 1'b0;
        start = 1'b0;
        check("job_finished", t_to < LIMIT, 1);
    endtask

    task automatic finish_job(input string tag, input int exp_issued, input bit full);
        obs_t   o;
        chunk_t ch;
        check({tag, "_issued"}, chunks_issued, exp_issued);
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                check({tag, "_extra_issue"}, o.base, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                ch = exp_q.pop_front();
                check({tag, "_base"}, o.base, ch.base);
                check({tag, "_count"}, o.cnt, ch.cnt);
                check({tag, "_onehot"}, o.onehot, 1);
            end
        end
        if (full) check({tag, "_sb_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int   n_obs, max_cyc;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        range_base = '0;
        range_end  = '0;
        chunk_size = '0;
        set_eng(5);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_key", found_key, 0);
        check("rst_issued", chunks_issued, 0);
        check("rst_start", eng_start, 0);
        check("rst_abort", eng_abort, 0);
        check("rst_perf", perf_cycles, 0);
        reset = 1'b0;
        @(negedge clk);

        push_chunks(32'd0, 32'd99, 16'd10);
        run_job(32'd0, 32'd99, 16'd10, -1, -1);
        check("basic_done", done, 1);
        check("basic_found", found, 0);
        check("basic_busy", busy, 0);
        finish_job("basic", 10, 1);
`ifdef MD5_SCHED_PERF_EN
        check("basic_perf", perf_cycles, busy_cyc);
`else
        check("basic_perf", perf_cycles, 0);
`endif

        push_chunks(32'd5, 32'd27, 16'd8);
        run_job(32'd5, 32'd27, 16'd8, -1, -1);
        check("part_done", done, 1);
        finish_job("part", 3, 1);

        push_chunks(32'hFFFF_FFF0, 32'hFFFF_FFFF, 16'd0);
        run_job(32'hFFFF_FFF0, 32'hFFFF_FFFF, 16'd0, -1, -1);
        check("top_done", done, 1);
        finish_job("top", 16, 1);

        run_job(32'd10, 32'd5, 16'd4, -1, -1);
        check("empty_latency", t_to, 1);
        check("empty_done", done, 1);
        check("empty_perf", perf_cycles, 0);
        finish_job("empty", 0, 1);

        push_chunks(32'd0, 32'd99, 16'd10);
        run_job(32'd0, 32'd99, 16'd10, -1, 5);
        check("restart_found", found, 0);
        finish_job("restart", 10, 1);

        // Engines 0, 2 and 3 finish their first chunk in the same cycle.
        lat  = '{13, 40, 11, 10};
        fnd  = '{1'b1, 1'b0, 1'b1, 1'b1};
        ekey = '{32'hAAAA_0000, 32'h0000_BBBB, 32'h0000_1234, 32'hDDDD_3333};
        push_chunks(32'd0, 32'd999, 16'd10);
        run_job(32'd0, 32'd999, 16'd10, -1, -1);
        check("match_found", found, 1);
        check("match_key", found_key, 32'hAAAA_0000);
        check("match_abort_seen", saw_abort, 1);
        check("match_abort_end", eng_abort, 0);
        check("match_done", done, 1);
        finish_job("match", 5, 0);
        set_eng(5);

        push_chunks(32'd0, 32'd999, 16'd10);
        run_job(32'd0, 32'd999, 16'd10, 8, -1);
        n_obs   = obs_q.size();
        max_cyc = 0;
        foreach (obs_q[i]) if (obs_q[i].cyc > max_cyc) max_cyc = obs_q[i].cyc;
        check("abort_no_late_issue", max_cyc <= ab_cyc, 1);
        check("abort_cut_short", n_obs < 100, 1);
        check("abort_found", found, 0);
        check("abort_done", done, 1);
        finish_job("abort", n_obs, 0);

        @(negedge clk);
        range_base = 32'd0;
        range_end  = 32'd999;
        chunk_size = 16'd10;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_found", found, 0);
        check("mid_rst_key", found_key, 0);
        check("mid_rst_issued", chunks_issued, 0);
        check("mid_rst_start", eng_start, 0);
        check("mid_rst_abort", eng_abort, 0);
        check("mid_rst_base", eng_base, 0);
        check("mid_rst_count", eng_count, 0);
        check("mid_rst_perf", perf_cycles, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        obs_q.delete();
        exp_q.delete();

        push_chunks(32'd5, 32'd27, 16'd8);
        run_job(32'd5, 32'd27, 16'd8, -1, -1);
        check("recover_done", done, 1);
        finish_job("recover", 3, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
